// File: rtl/hamming_cost_gen.sv
// hamming_cost_gen: candidate-cost generator for binary (census) block matching.
// Accepts one reference block, scans every candidate offset of the search
// window (v ascending, h descending), and streams ref^candidate plus its
// saturated popcount, one candidate per cycle, three cycles after each read.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ref_bits, blk_index_i      reference block and its index (ref_valid/ref_ready)
//   cand_rd_en, cand_addr      candidate read strobe and {v,h} offset
//   cand_data                  candidate bits, valid the cycle after cand_rd_en
//   xors, sum, out_coords,
//   blk_index_o, sum_valid     result stream to the minimum-distance finder
//   busy                       scanner not idle
module hamming_cost_gen #(
  parameter int unsigned BLK_W        = 16,
  parameter int unsigned BLK_H        = 16,
  parameter int unsigned SEARCH_BLK_W = 64,
  parameter int unsigned SEARCH_BLK_H = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BLK_W*BLK_H-1:0]   ref_bits,
  input  logic [15:0]              blk_index_i,
  input  logic                     ref_valid,
  output logic                     ref_ready,
  output logic                     cand_rd_en,
  output logic [15:0]              cand_addr,
  input  logic [BLK_W*BLK_H-1:0]   cand_data,
  output logic [BLK_W*BLK_H-1:0]   xors,
  output logic [7:0]               sum,
  output logic [15:0]              out_coords,
  output logic [15:0]              blk_index_o,
  output logic                     sum_valid,
  output logic                     busy
);

  localparam int unsigned BLK_SIZE  = BLK_W * BLK_H;
  localparam int unsigned N_H       = SEARCH_BLK_W - BLK_W;
  localparam int unsigned N_V       = SEARCH_BLK_H - BLK_H;
  localparam int unsigned NPART     = BLK_SIZE / 16;
  localparam int unsigned SUM_W     = $clog2(BLK_SIZE + 1);
  localparam int unsigned DRAIN_CYC = 3;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t                state_q;
  logic [7:0]            v_q, h_q;
  logic [1:0]            drain_cnt_q;
  logic [BLK_SIZE-1:0]   ref_q;
  logic [15:0]           idx_q;
  logic                  ref_ready_q, busy_q, rd_en_q;

  // Stage 1: coordinates/index delayed to line up with cand_data arrival
  logic                  s1_valid_q;
  logic [15:0]           s1_coords_q, s1_idx_q;
  // Stage 2: XOR vector and 16-bit partial popcounts
  logic                  s2_valid_q;
  logic [15:0]           s2_coords_q, s2_idx_q;
  logic [BLK_SIZE-1:0]   s2_xors_q;
  logic [4:0]            s2_part_q [NPART];
  // Output stage
  logic                  sum_valid_q;
  logic [15:0]           out_coords_q, blk_index_q;
  logic [BLK_SIZE-1:0]   xors_q;
  logic [7:0]            sum_q;

  logic [BLK_SIZE-1:0]   xor_c;
  logic [4:0]            part_c [NPART];
  logic [SUM_W-1:0]      total_c;
  logic [7:0]            sat_c;

  function automatic logic [4:0] pop16(input logic [15:0] x);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(x[i]);
    return c;
  endfunction

  // Scan controller: accept, raster the window, then drain the pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      v_q         <= '0;
      h_q         <= '0;
      drain_cnt_q <= '0;
      ref_q       <= '0;
      idx_q       <= '0;
      ref_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ref_valid && ref_ready_q) begin
            ref_q       <= ref_bits;
            idx_q       <= blk_index_i;
            v_q         <= '0;
            h_q         <= 8'(N_H - 1);
            rd_en_q     <= 1'b1;
            ref_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= SCAN;
          end
        end
        SCAN: begin
          // {n_v-1, 0} must be the final read: the consumer keys end-of-block on it
          if (v_q == 8'(N_V - 1) && h_q == '0) begin
            rd_en_q     <= 1'b0;
            drain_cnt_q <= 2'(DRAIN_CYC - 1);
            state_q     <= DRAIN;
          end else if (h_q == '0) begin
            h_q <= 8'(N_H - 1);
            v_q <= v_q + 8'd1;
          end else begin
            h_q <= h_q - 8'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt_q == '0) begin
            ref_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            drain_cnt_q <= drain_cnt_q - 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // XOR against the latched reference and form partial popcounts
  always_comb begin
    xor_c = ref_q ^ cand_data;
    for (int p = 0; p < NPART; p++) part_c[p] = pop16(xor_c[p*16 +: 16]);
  end

  // Sum partials; anything above 255 saturates
  always_comb begin
    total_c = '0;
    for (int p = 0; p < NPART; p++) total_c = total_c + SUM_W'(s2_part_q[p]);
    sat_c = (total_c > SUM_W'(255)) ? 8'hFF : 8'(total_c);
  end

  // Result pipeline; data registers only load with a valid candidate
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_coords_q  <= '0;
      s1_idx_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_coords_q  <= '0;
      s2_idx_q     <= '0;
      s2_xors_q    <= '0;
      for (int p = 0; p < NPART; p++) s2_part_q[p] <= '0;
      sum_valid_q  <= 1'b0;
      out_coords_q <= '0;
      blk_index_q  <= '0;
      xors_q       <= '0;
      sum_q        <= '0;
    end else begin
      s1_valid_q  <= rd_en_q;
      s2_valid_q  <= s1_valid_q;
      sum_valid_q <= s2_valid_q;
      if (rd_en_q) begin
        s1_coords_q <= {v_q, h_q};
        s1_idx_q    <= idx_q;
      end
      if (s1_valid_q) begin
        s2_coords_q <= s1_coords_q;
        s2_idx_q    <= s1_idx_q;
        s2_xors_q   <= xor_c;
        for (int p = 0; p < NPART; p++) s2_part_q[p] <= part_c[p];
      end
      if (s2_valid_q) begin
        out_coords_q <= s2_coords_q;
        blk_index_q  <= s2_idx_q;
        xors_q       <= s2_xors_q;
        sum_q        <= sat_c;
      end
    end
  end

  assign ref_ready   = ref_ready_q;
  assign busy        = busy_q;
  assign cand_rd_en  = rd_en_q;
  assign cand_addr   = {v_q, h_q};
  assign xors        = xors_q;
  assign sum         = sum_q;
  assign out_coords  = out_coords_q;
  assign blk_index_o = blk_index_q;
  assign sum_valid   = sum_valid_q;

endmodule

// File: tb/tb_hamming_cost_gen.sv
// tb_hamming_cost_gen: directed bench for hamming_cost_gen. A window-buffer
// model answers reads one cycle later; a monitor checks every result against
// an expected raster order and a popcount model.
module tb_hamming_cost_gen;

  localparam int NH = 48;
  localparam int NV = 4;
  localparam int N  = NH * NV;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] ref_bits;
  logic [15:0]  blk_index_i;
  logic         ref_valid;
  logic         ref_ready;
  logic         cand_rd_en;
  logic [15:0]  cand_addr;
  logic [255:0] cand_data;
  logic [255:0] xors;
  logic [7:0]   sum;
  logic [15:0]  out_coords;
  logic [15:0]  blk_index_o;
  logic         sum_valid;
  logic         busy;

  hamming_cost_gen dut (
    .clk(clk), .reset(reset), .ref_bits(ref_bits), .blk_index_i(blk_index_i),
    .ref_valid(ref_valid), .ref_ready(ref_ready), .cand_rd_en(cand_rd_en),
    .cand_addr(cand_addr), .cand_data(cand_data), .xors(xors), .sum(sum),
    .out_coords(out_coords), .blk_index_o(blk_index_o), .sum_valid(sum_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Candidate generation mode: 0 zero, 1 ~ref, 2 ref with 3 bits flipped at 0x0205
  int           cur_mode;
  logic [255:0] cur_ref;
  logic [255:0] flip_v;
  logic [15:0]  exp_idx [2];

  // Monitor state
  int           k;
  int           nz;
  int           hit;
  logic [15:0]  last_c;
  int           kk, blk, pc;
  logic [15:0]  exp_c;
  logic [255:0] exp_x;
  logic [7:0]   exp_s;

  typedef struct {
    int           mode;
    logic [255:0] ref_v;
    logic [15:0]  idx;
    int           exp_nz;
    int           exp_hit;
  } vec_t;
  vec_t tbl [3];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [255:0] gen(input logic [15:0] a);
    case (cur_mode)
      0:       return '0;
      1:       return ~cur_ref;
      default: return (a == 16'h0205) ? (cur_ref ^ flip_v) : cur_ref;
    endcase
  endfunction

  // Window buffer model: data one cycle after the read strobe
  always @(posedge clk) begin
    if (cand_rd_en === 1'b1) cand_data <= gen(cand_addr);
  end

  // Result monitor
  always @(negedge clk) begin
    if (sum_valid === 1'b1) begin
      kk    = k % N;
      blk   = (k / N > 1) ? 1 : k / N;
      exp_c = {8'(kk / NH), 8'(NH - 1 - kk % NH)};
      exp_x = cur_ref ^ gen(exp_c);
      pc    = $countones(exp_x);
      exp_s = (pc > 255) ? 8'd255 : 8'(pc);
      chk("coords", 256'(out_coords), 256'(exp_c));
      chk("xors", xors, exp_x);
      chk("sum", 256'(sum), 256'(exp_s));
      chk("blk_index_o", 256'(blk_index_o), 256'(exp_idx[blk]));
      if (sum != 8'd0) nz++;
      if (out_coords == 16'h0205) hit = int'(sum);
      last_c = out_coords;
      k++;
    end
  end

  task automatic run_one(input int mode, input logic [255:0] r, input logic [15:0] idx,
                         input int exp_nz, input int exp_hit);
    int rd, rl, first, last;
    cur_mode   = mode;
    cur_ref    = r;
    exp_idx[0] = idx;
    exp_idx[1] = idx;
    k = 0; nz = 0; hit = -1;
    rd = 0; rl = 0; first = -1; last = -1;
    @(negedge clk);
    chk("ready_before_accept", 256'(ref_ready), 256'(1));
    ref_bits    = r;
    blk_index_i = idx;
    ref_valid   = 1'b1;
    for (int c = 1; c <= N + 6; c++) begin
      @(negedge clk);
      if (c == 1) ref_valid = 1'b0;
      if (cand_rd_en) rd++;
      if (!ref_ready) rl++;
      if (sum_valid) begin
        if (first < 0) first = c;
        last = c;
      end
    end
    chk("read_count", 256'(rd), 256'(N));
    chk("ready_low_cycles", 256'(rl), 256'(N + 3));
    chk("first_valid_cycle", 256'(first), 256'(4));
    chk("last_valid_cycle", 256'(last), 256'(N + 3));
    chk("result_count", 256'(k), 256'(N));
    chk("nonzero_sums", 256'(nz), 256'(exp_nz));
    chk("sum_at_0205", 256'(hit), 256'(exp_hit));
    chk("last_coords", 256'(last_c), 256'(16'h0300));
  endtask

  initial begin
    int rl, first2, last1, rd, sv;
    logic rdy_n4;
    flip_v = '0;
    flip_v[0] = 1'b1; flip_v[100] = 1'b1; flip_v[255] = 1'b1;
    cur_mode = 0; cur_ref = '0; exp_idx[0] = '0; exp_idx[1] = '0;
    k = 0; nz = 0; hit = -1; last_c = '0;
    cand_data = '0; ref_bits = '0; blk_index_i = '0; ref_valid = 1'b0;

    tbl[0] = '{mode: 0, ref_v: '0,             idx: 16'h0012, exp_nz: 0,   exp_hit: 0};
    tbl[1] = '{mode: 1, ref_v: {32{8'hA5}},    idx: 16'h0034, exp_nz: 192, exp_hit: 255};
    tbl[2] = '{mode: 2, ref_v: {32{8'h3C}},    idx: 16'h0056, exp_nz: 1,   exp_hit: 3};

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_ref_ready", 256'(ref_ready), 256'(1));
      chk("idle_busy", 256'(busy), 256'(0));
      chk("idle_sum_valid", 256'(sum_valid), 256'(0));
      chk("idle_rd_en", 256'(cand_rd_en), 256'(0));
      chk("idle_data", {xors[255:56], sum, out_coords, blk_index_o, cand_addr} | xors, 256'(0));
    end

    for (int t = 0; t < 3; t++)
      run_one(tbl[t].mode, tbl[t].ref_v, tbl[t].idx, tbl[t].exp_nz, tbl[t].exp_hit);

    // Back-to-back blocks with ref_valid held high
    cur_mode = 2; cur_ref = {32{8'h3C}};
    exp_idx[0] = 16'h0001; exp_idx[1] = 16'h0002;
    k = 0; nz = 0; hit = -1;
    rl = 0; first2 = -1; last1 = -1; rd = 0; rdy_n4 = 1'b0;
    @(negedge clk);
    ref_bits = cur_ref; blk_index_i = 16'h0001; ref_valid = 1'b1;
    for (int c = 1; c <= 2 * N + 12; c++) begin
      @(negedge clk);
      if (c == 1) blk_index_i = 16'h0002;
      if (c <= N + 3 && !ref_ready) rl++;
      if (c == N + 4) rdy_n4 = ref_ready;
      if (c == N + 5) begin
        chk("b2b_ready_low_after_second", 256'(ref_ready), 256'(0));
        ref_valid = 1'b0;
      end
      if (cand_rd_en) rd++;
      if (sum_valid) begin
        if (c <= N + 3) last1 = c;
        else if (first2 < 0) first2 = c;
      end
    end
    chk("b2b_ready_low_cycles", 256'(rl), 256'(N + 3));
    chk("b2b_ready_at_N4", 256'(rdy_n4), 256'(1));
    chk("b2b_last_first_block", 256'(last1), 256'(N + 3));
    chk("b2b_first_second_block", 256'(first2), 256'(N + 8));
    chk("b2b_read_count", 256'(rd), 256'(2 * N));
    chk("b2b_result_count", 256'(k), 256'(2 * N));

    // Reset during the 50th read
    cur_mode = 1; cur_ref = {32{8'hA5}};
    exp_idx[0] = 16'h0077; exp_idx[1] = 16'h0077;
    k = 0;
    @(negedge clk);
    ref_bits = cur_ref; blk_index_i = 16'h0077; ref_valid = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 1) ref_valid = 1'b0;
    end
    chk("rst_mid_rd_en_before", 256'(cand_rd_en), 256'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_sum_valid", 256'(sum_valid), 256'(0));
    chk("rst_rd_en", 256'(cand_rd_en), 256'(0));
    chk("rst_ref_ready", 256'(ref_ready), 256'(1));
    chk("rst_busy", 256'(busy), 256'(0));
    sv = 0; rd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (sum_valid) sv++;
      if (cand_rd_en) rd++;
    end
    chk("rst_no_results", 256'(sv), 256'(0));
    chk("rst_no_reads", 256'(rd), 256'(0));
    chk("rst_results_before", 256'(k), 256'(47));
    run_one(1, {32{8'hA5}}, 16'h0099, 192, 255);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
